// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter that shares one I2C master engine between NREQ clients.
// Launches the winner's descriptor, then follows the master's state code to stream bytes and detect the end.
module i2c_bus_arbiter #(
   parameter int NREQ          = 4,
   parameter int ADDRESSLENGTH = 7,
   parameter int TIMEOUT       = 4095
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [NREQ-1:0]               req,
   input  logic [NREQ*ADDRESSLENGTH-1:0] req_addr,
   input  logic [NREQ-1:0]               req_rorw,
   input  logic [NREQ*4-1:0]             req_nbytes,
   input  logic [NREQ*8-1:0]             req_wdata,
   output logic [NREQ-1:0]               grant,
   output logic                          wr_ready,
   output logic                          rd_valid,
   output logic [7:0]                    rd_data,
   output logic                          done,
   output logic                          err,
   output logic                          m_start,
   output logic                          m_rorw,
   output logic [ADDRESSLENGTH-1:0]      m_addr,
   output logic [3:0]                    m_nbytes,
   output logic [7:0]                    m_wdata,
   input  logic [7:0]                    m_rdata,
   input  logic [3:0]                    m_state
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {ARB, LAUNCH, RUN, FIN} state_t;
   state_t state, state_n;

   logic [3:0] q1, q2, q3, sst;
   logic       chg;
   logic [PW-1:0] ptr, ptr_n;
   logic [TW-1:0] tmr, tmr_n;
   logic [3:0] bytes, bytes_n;
   logic       fin_err, fin_err_n;
   logic [NREQ-1:0] grant_n;
   logic [7:0] rd_data_n;
   logic [ADDRESSLENGTH-1:0] m_addr_n;
   logic [3:0] m_nbytes_n;
   logic       m_rorw_n, wr_ready_n, rd_valid_n, done_n, err_n;
   logic       found;
   int         win, idx;

   // Synchronizer chain is left unreset so a reset never fakes an Idle code;
   // sst resets to an impossible code so arbitration waits for a real Idle.
   always_ff @(posedge CLK) begin
      q1 <= m_state;
      q2 <= q1;
      q3 <= q2;
   end

   assign chg = (q2 == q3) && (q2 != sst);

   always_ff @(posedge CLK) begin
      if (!RST)     sst <= 4'hF;
      else if (chg) sst <= q2;
   end

   always_comb begin
      m_wdata = '0;
      for (int i = 0; i < NREQ; i++)
         if (grant[i]) m_wdata = m_wdata | req_wdata[i*8 +: 8];
   end

   always_comb begin
      found = 1'b0;
      win   = 0;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(ptr) + k) % NREQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   assign m_start = (state == LAUNCH);

   always_comb begin
      state_n    = state;
      grant_n    = grant;
      ptr_n      = ptr;
      tmr_n      = tmr;
      bytes_n    = bytes;
      fin_err_n  = fin_err;
      rd_data_n  = rd_data;
      m_addr_n   = m_addr;
      m_rorw_n   = m_rorw;
      m_nbytes_n = m_nbytes;
      wr_ready_n = 1'b0;
      rd_valid_n = 1'b0;
      done_n     = 1'b0;
      err_n      = 1'b0;
      case (state)
         ARB: begin
            // grant is held through the done cycle and cleared here
            grant_n = '0;
            if (!done && found && sst == 4'd0) begin
               grant_n[win] = 1'b1;
               m_addr_n     = req_addr[win*ADDRESSLENGTH +: ADDRESSLENGTH];
               m_rorw_n     = req_rorw[win];
               m_nbytes_n   = req_nbytes[win*4 +: 4];
               ptr_n        = PW'((win + 1) % NREQ);
               bytes_n      = '0;
               tmr_n        = '0;
               state_n      = LAUNCH;
            end
         end
         LAUNCH, RUN: begin
            if (chg) begin
               tmr_n = '0;
               if (state == LAUNCH) begin
                  if (q2 != 4'd0) state_n = RUN;
               end else begin
                  if (sst == 4'd5 && q2 == 4'd4) begin
                     wr_ready_n = 1'b1;
                     if (bytes != 4'hF) bytes_n = bytes + 4'd1;
                  end
                  if (sst == 4'd6 && q2 == 4'd7) begin
                     rd_data_n  = m_rdata;
                     rd_valid_n = 1'b1;
                     if (bytes != 4'hF) bytes_n = bytes + 4'd1;
                  end
                  if (q2 == 4'd1) begin
                     fin_err_n = (bytes != m_nbytes);
                     state_n   = FIN;
                  end
               end
            end else if (tmr == TW'(TIMEOUT - 1)) begin
               done_n  = 1'b1;
               err_n   = 1'b1;
               state_n = ARB;
            end else begin
               tmr_n = tmr + TW'(1);
            end
         end
         FIN: begin
            if (chg && q2 == 4'd0) begin
               done_n  = 1'b1;
               err_n   = fin_err;
               state_n = ARB;
            end
         end
         default: state_n = ARB;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state    <= ARB;
         grant    <= '0;
         ptr      <= '0;
         tmr      <= '0;
         bytes    <= '0;
         fin_err  <= 1'b0;
         rd_data  <= '0;
         m_addr   <= '0;
         m_rorw   <= 1'b0;
         m_nbytes <= '0;
         wr_ready <= 1'b0;
         rd_valid <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_n;
         grant    <= grant_n;
         ptr      <= ptr_n;
         tmr      <= tmr_n;
         bytes    <= bytes_n;
         fin_err  <= fin_err_n;
         rd_data  <= rd_data_n;
         m_addr   <= m_addr_n;
         m_rorw   <= m_rorw_n;
         m_nbytes <= m_nbytes_n;
         wr_ready <= wr_ready_n;
         rd_valid <= rd_valid_n;
         done     <= done_n;
         err      <= err_n;
      end
   end
endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter: a hand-stepped master state model drives m_state,
// and every step is checked against hand-computed values with immediate assertions.
module tb_i2c_bus_arbiter;
   localparam int NREQ = 4;
   localparam int AL   = 7;
   localparam int TO   = 31;

   logic              CLK = 1'b0;
   logic              RST = 1'b0;
   logic [NREQ-1:0]   req = '0;
   logic [NREQ*AL-1:0] req_addr = '0;
   logic [NREQ-1:0]   req_rorw = '0;
   logic [NREQ*4-1:0] req_nbytes = '0;
   logic [NREQ*8-1:0] req_wdata = '0;
   logic [NREQ-1:0]   grant;
   logic              wr_ready, rd_valid, done, err, m_start, m_rorw;
   logic [7:0]        rd_data, m_wdata;
   logic [AL-1:0]     m_addr;
   logic [3:0]        m_nbytes;
   logic [7:0]        m_rdata = '0;
   logic [3:0]        m_state = '0;

   int errors = 0;
   int checks = 0;
   int n_wr = 0, n_rd = 0, n_done = 0, n_ovl = 0;
   logic            d_err = 1'b0;
   logic [NREQ-1:0] d_grant = '0;
   logic [7:0]      rd_log [16];
   int b_wr, b_rd, b_done;
   logic [NREQ-1:0] rr_exp [5];

   i2c_bus_arbiter #(.NREQ(NREQ), .ADDRESSLENGTH(AL), .TIMEOUT(TO)) dut (
      .CLK(CLK), .RST(RST), .req(req), .req_addr(req_addr), .req_rorw(req_rorw),
      .req_nbytes(req_nbytes), .req_wdata(req_wdata), .grant(grant),
      .wr_ready(wr_ready), .rd_valid(rd_valid), .rd_data(rd_data), .done(done),
      .err(err), .m_start(m_start), .m_rorw(m_rorw), .m_addr(m_addr),
      .m_nbytes(m_nbytes), .m_wdata(m_wdata), .m_rdata(m_rdata), .m_state(m_state)
   );

   always #5 CLK = ~CLK;

   // Pulse monitor, sampled mid-cycle
   always @(negedge CLK) begin
      if (wr_ready) n_wr <= n_wr + 1;
      if (rd_valid) begin
         rd_log[n_rd % 16] <= rd_data;
         n_rd <= n_rd + 1;
      end
      if (done) begin
         n_done  <= n_done + 1;
         d_err   <= err;
         d_grant <= grant;
      end
      if (int'(wr_ready) + int'(rd_valid) + int'(done) > 1) n_ovl <= n_ovl + 1;
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // each code is held long enough for the 2-flop sync plus the stability check
   task automatic ms(input logic [3:0] st);
      m_state = st;
      repeat (6) step();
   endtask

   task automatic wait_start(input string tag);
      for (int i = 0; i < 40 && !m_start; i++) step();
      chk(tag, {31'd0, m_start}, 32'd1);
   endtask

   task automatic set_lane(input int i, input logic [6:0] a, input logic rw,
                           input logic [3:0] nb, input logic [7:0] wd);
      req_addr[i*AL +: AL] = a;
      req_rorw[i]          = rw;
      req_nbytes[i*4 +: 4] = nb;
      req_wdata[i*8 +: 8]  = wd;
   endtask

   task automatic snap();
      b_wr = n_wr; b_rd = n_rd; b_done = n_done;
   endtask

   task automatic probe_seq();
      ms(4'd2); ms(4'd3); ms(4'd4); ms(4'd1); ms(4'd0);
   endtask

   initial begin
      rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
      rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
      repeat (5) step();
      RST = 1'b1;
      step();
      chk("reset_grant", {28'd0, grant}, 32'd0);
      chk("reset_outs", {wr_ready, rd_valid, done, err, m_start}, 32'd0);

      // single write, lane 1, 2 bytes; req dropped after grant must not matter
      set_lane(1, 7'h50, 1'b1, 4'd2, 8'h11);
      req = 4'b0010;
      snap();
      wait_start("w_start");
      chk("w_grant", {28'd0, grant}, 32'h2);
      chk("w_desc", {m_rorw, m_nbytes, 1'b0, m_addr}, {20'd0, 1'b1, 4'd2, 8'h50});
      chk("w_wdata0", {24'd0, m_wdata}, 32'h11);
      req = 4'b0000;
      ms(4'd0);
      chk("w_start_held", {31'd0, m_start}, 32'd1);
      m_state = 4'd2; step(); step();
      chk("w_start_pre2", {31'd0, m_start}, 32'd1);
      repeat (4) step();
      chk("w_start_off", {31'd0, m_start}, 32'd0);
      ms(4'd3); ms(4'd4); ms(4'd5); ms(4'd4);
      chk("w_wr1", n_wr - b_wr, 32'd1);
      req_wdata[1*8 +: 8] = 8'h22;
      step();
      chk("w_wdata1", {24'd0, m_wdata}, 32'h22);
      ms(4'd5); ms(4'd4); ms(4'd1);
      chk("w_no_done_yet", n_done - b_done, 32'd0);
      ms(4'd0);
      chk("w_wr2", n_wr - b_wr, 32'd2);
      chk("w_done", n_done - b_done, 32'd1);
      chk("w_err", {31'd0, d_err}, 32'd0);
      chk("w_done_grant", {28'd0, d_grant}, 32'h2);
      chk("w_grant_off", {28'd0, grant}, 32'd0);

      // read, lane 0, 3 bytes
      set_lane(0, 7'h21, 1'b0, 4'd3, 8'h00);
      req = 4'b0001;
      snap();
      wait_start("r_start");
      chk("r_grant", {28'd0, grant}, 32'h1);
      chk("r_dir", {31'd0, m_rorw}, 32'd0);
      req = 4'b0000;
      ms(4'd2); ms(4'd3); ms(4'd4);
      ms(4'd6); m_rdata = 8'hA5; ms(4'd7);
      ms(4'd6); m_rdata = 8'h3C; ms(4'd7);
      ms(4'd6); m_rdata = 8'hFF; ms(4'd7);
      ms(4'd1); ms(4'd0);
      chk("r_cnt", n_rd - b_rd, 32'd3);
      chk("r_b0", {24'd0, rd_log[b_rd % 16]}, 32'hA5);
      chk("r_b1", {24'd0, rd_log[(b_rd + 1) % 16]}, 32'h3C);
      chk("r_b2", {24'd0, rd_log[(b_rd + 2) % 16]}, 32'hFF);
      chk("r_done", n_done - b_done, 32'd1);
      chk("r_err", {31'd0, d_err}, 32'd0);
      chk("r_no_wr", n_wr - b_wr, 32'd0);

      // round robin from a fresh pointer, address-only probes
      RST = 1'b0; step(); step(); RST = 1'b1; step();
      for (int i = 0; i < NREQ; i++) set_lane(i, 7'(8'h10 + i), 1'b1, 4'd0, 8'h00);
      req = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         snap();
         wait_start("rr_start");
         chk($sformatf("rr_grant%0d", t), {28'd0, grant}, {28'd0, rr_exp[t]});
         if (t == 4) req = 4'b0000;
         probe_seq();
         chk($sformatf("rr_done%0d", t), n_done - b_done, 32'd1);
         chk($sformatf("rr_err%0d", t), {31'd0, d_err}, 32'd0);
      end

      // NACK after address: no data phase, byte count short
      set_lane(2, 7'h33, 1'b1, 4'd2, 8'h44);
      req = 4'b0100;
      snap();
      wait_start("n_start");
      chk("n_grant", {28'd0, grant}, 32'h4);
      req = 4'b0000;
      ms(4'd2); ms(4'd3); ms(4'd4); ms(4'd1); ms(4'd0);
      chk("n_no_wr", n_wr - b_wr, 32'd0);
      chk("n_done", n_done - b_done, 32'd1);
      chk("n_err", {31'd0, d_err}, 32'd1);

      // timeout: stuck in TxData; sst sees the change 4 cycles after m_state moves
      set_lane(3, 7'h44, 1'b1, 4'd1, 8'h55);
      req = 4'b1000;
      snap();
      wait_start("t_start");
      chk("t_grant", {28'd0, grant}, 32'h8);
      ms(4'd2); ms(4'd3); ms(4'd4);
      m_state = 4'd5;
      repeat (34) step();
      chk("t_done_early", {31'd0, done}, 32'd0);
      step();
      chk("t_done", {30'd0, done, err}, 32'd3);
      chk("t_grant_held", {28'd0, grant}, 32'h8);
      step();
      chk("t_grant_off", {28'd0, grant}, 32'd0);
      req_nbytes[3*4 +: 4] = 4'd0;
      repeat (20) step();
      chk("t_no_regrant", {27'd0, grant, m_start}, 32'd0);
      snap();
      m_state = 4'd0;
      wait_start("t_restart");
      chk("t_regrant", {28'd0, grant}, 32'h8);
      req = 4'b0000;
      probe_seq();
      chk("t_probe_err", {31'd0, d_err}, 32'd0);

      // reset in the middle of a read after one byte
      set_lane(0, 7'h2A, 1'b0, 4'd3, 8'h00);
      req = 4'b0001;
      snap();
      wait_start("x_start");
      ms(4'd2); ms(4'd3); ms(4'd4); ms(4'd6); m_rdata = 8'h5A; ms(4'd7);
      chk("x_byte", {24'd0, rd_data}, 32'h5A);
      RST = 1'b0;
      step();
      chk("x_rst_ctl", {26'd0, grant, m_start, done}, 32'd0);
      chk("x_rst_data", {4'd0, rd_data, m_addr, m_nbytes, m_rorw, err, wr_ready, rd_valid, 5'd0},
          32'd0);
      RST = 1'b1;
      req_nbytes[0*4 +: 4] = 4'd0;
      repeat (15) step();
      chk("x_no_grant", {27'd0, grant, m_start}, 32'd0);
      snap();
      m_state = 4'd0;
      wait_start("x_restart");
      chk("x_regrant", {28'd0, grant}, 32'h1);
      req = 4'b0000;
      probe_seq();
      chk("x_done", n_done - b_done, 32'd1);
      chk("x_err", {31'd0, d_err}, 32'd0);

      chk("no_overlap", n_ovl, 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
